pc_seq: RTL and testbench



---
 rtl/pc_pkg.sv | 34 +++
 rtl/ret_stack.sv | 46 ++++
 rtl/pc_seq.sv | 97 +++++++++
 tb/tb_pc_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Purpose: shared types and the command priority decoder for the program counter.
// Latency: none; types and a pure function only.
// Backpressure: none; the decoder collapses concurrent strobes to a single operation.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_UP,
    PC_BR,
    PC_LD,
    PC_CALL,
    PC_RET
  } pc_op_e;

  // Fixed priority Ret > Call > Ld > Br > Up > hold. Losing strobes are dropped
  // here, so nothing downstream ever sees them.
  function automatic pc_op_e pc_decode(
    input logic up,
    input logic br,
    input logic ld,
    input logic call,
    input logic ret
  );
    pc_op_e op;
    if (ret)       op = PC_RET;
    else if (call) op = PC_CALL;
    else if (ld)   op = PC_LD;
    else if (br)   op = PC_BR;
    else if (up)   op = PC_UP;
    else           op = PC_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Purpose: LIFO of return addresses with an occupancy count.
//   Ports: i_clk, i_clr (async active-low), i_push/i_pop strobes, i_din in,
//   o_dout = top entry (combinational from registers), o_full/o_empty from count.
// Latency: push/pop take effect at the next rising edge. Backpressure: push when
//   full and pop when empty are ignored here; the caller flags them.
module ret_stack #(
  parameter int AW    = 7,
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_din,
  output logic [AW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_top;

  // Index of the newest entry; pinned to 0 when empty so the read stays in range.
  assign w_top   = (r_cnt == '0) ? '0 : r_cnt - CW'(1);
  assign o_dout  = r_mem[w_top[IW-1:0]];
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !o_full) begin
      r_mem[r_cnt[IW-1:0]] <= i_din;
      r_cnt                <= r_cnt + CW'(1);
    end else if (i_pop && !o_empty) begin
      // Popped slot is left as-is; it is overwritten by the next push.
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Purpose: instruction-memory program counter with increment, jump, relative
//   branch and call/return through a hardware return stack.
//   Ports: i_clk, i_clr (async active-low), strobes i_up/i_br/i_ld/i_call/i_ret,
//   i_off (signed offset), i_tgt; outputs o_addr, o_full, o_empty, o_err (sticky).
// Latency: one edge, every output registered. Backpressure: none; one command per
//   cycle, call-on-full / return-on-empty leave state intact and set o_err.
module pc_seq
  import pc_pkg::*;
#(
  parameter int AW    = 7,
  parameter int DEPTH = 4,
  parameter bit SAT   = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_up,
  input  logic          i_br,
  input  logic [AW-1:0] i_off,
  input  logic          i_ld,
  input  logic          i_call,
  input  logic          i_ret,
  input  logic [AW-1:0] i_tgt,
  output logic [AW-1:0] o_addr,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_err
);

  localparam logic [AW-1:0] ADDR_MAX = '1;

  logic [AW-1:0] r_addr;
  logic          r_err;

  pc_op_e        w_op;
  logic [AW-1:0] w_inc;
  logic [AW-1:0] w_br;
  logic [AW-1:0] w_top;
  logic [AW-1:0] w_next;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_fault;

  assign w_op = pc_decode(i_up, i_br, i_ld, i_call, i_ret);

  // Increment honours the end policy; the same value is the pushed return address.
  assign w_inc = (r_addr == ADDR_MAX) ? (SAT ? ADDR_MAX : '0) : r_addr + AW'(1);
  // Two's-complement add truncated to AW bits is the signed, always-wrapping branch.
  assign w_br  = r_addr + i_off;

  assign w_push  = (w_op == PC_CALL) && !w_full;
  assign w_pop   = (w_op == PC_RET)  && !w_empty;
  assign w_fault = ((w_op == PC_CALL) && w_full) || ((w_op == PC_RET) && w_empty);

  always_comb begin
    w_next = r_addr;
    unique case (w_op)
      PC_UP:   w_next = w_inc;
      PC_BR:   w_next = w_br;
      PC_LD:   w_next = i_tgt;
      PC_CALL: if (!w_full)  w_next = i_tgt;
      PC_RET:  if (!w_empty) w_next = w_top;
      default: w_next = r_addr;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_addr <= '0;
      r_err  <= 1'b0;
    end else begin
      r_addr <= w_next;
      if (w_fault) r_err <= 1'b1;
    end
  end

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .i_clk   (i_clk),
    .i_clr   (i_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_inc),
    .o_dout  (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_addr  = r_addr;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_err   = r_err;

endmodule

// File: tb/tb_pc_seq.sv
// Purpose: self-checking bench for pc_seq, one saturating and one wrapping instance
//   driven in lockstep and compared against a queue-free array model.
// Latency: checks one edge after each command, sampled 1 ns after the rising edge.
module tb_pc_seq;

  localparam int AW    = 7;
  localparam int DEPTH = 4;
  localparam int AMAX  = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          i_up = 1'b0, i_br = 1'b0, i_ld = 1'b0, i_call = 1'b0, i_ret = 1'b0;
  logic [AW-1:0] i_off = '0, i_tgt = '0;

  logic [AW-1:0] d_addr  [2];
  logic          d_full  [2];
  logic          d_empty [2];
  logic          d_err   [2];

  int total = 0;
  int bad   = 0;

  // Reference model: [0] saturating, [1] wrapping.
  int m_addr [2];
  int m_stk  [2][DEPTH];
  int m_sp   [2];
  bit m_err  [2];

  always #5 clk = ~clk;

  pc_seq #(.AW(AW), .DEPTH(DEPTH), .SAT(1'b1)) u_sat (
    .i_clk(clk), .i_clr(clr), .i_up(i_up), .i_br(i_br), .i_off(i_off), .i_ld(i_ld),
    .i_call(i_call), .i_ret(i_ret), .i_tgt(i_tgt), .o_addr(d_addr[0]),
    .o_full(d_full[0]), .o_empty(d_empty[0]), .o_err(d_err[0])
  );

  pc_seq #(.AW(AW), .DEPTH(DEPTH), .SAT(1'b0)) u_wrap (
    .i_clk(clk), .i_clr(clr), .i_up(i_up), .i_br(i_br), .i_off(i_off), .i_ld(i_ld),
    .i_call(i_call), .i_ret(i_ret), .i_tgt(i_tgt), .o_addr(d_addr[1]),
    .o_full(d_full[1]), .o_empty(d_empty[1]), .o_err(d_err[1])
  );

  function automatic int next_up(input int a, input int k);
    if (a == AMAX) return (k == 0) ? AMAX : 0;
    return a + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = 0; m_sp[k] = 0; m_err[k] = 1'b0;
    end
  endtask

  // Applies the command currently on the inputs, highest priority strobe first.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (i_ret) begin
        if (m_sp[k] == 0) m_err[k] = 1'b1;
        else begin m_sp[k] = m_sp[k] - 1; m_addr[k] = m_stk[k][m_sp[k]]; end
      end else if (i_call) begin
        if (m_sp[k] == DEPTH) m_err[k] = 1'b1;
        else begin
          m_stk[k][m_sp[k]] = next_up(m_addr[k], k);
          m_sp[k] = m_sp[k] + 1;
          m_addr[k] = int'(i_tgt);
        end
      end else if (i_ld) m_addr[k] = int'(i_tgt);
      else if (i_br) m_addr[k] = (m_addr[k] + int'(i_off)) % (AMAX + 1);
      else if (i_up) m_addr[k] = next_up(m_addr[k], k);
    end
  endtask

  task automatic do_op(input logic up, input logic br, input logic ld, input logic call,
                       input logic ret, input logic [AW-1:0] off, input logic [AW-1:0] tgt);
    @(negedge clk);
    i_up = up; i_br = br; i_ld = ld; i_call = call; i_ret = ret; i_off = off; i_tgt = tgt;
    @(posedge clk);
    model_step();
    #1;
    i_up = 1'b0; i_br = 1'b0; i_ld = 1'b0; i_call = 1'b0; i_ret = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b0; i_up = 1'b1; i_ld = 1'b1; i_tgt = 7'd55;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (d_addr[k] !== 7'd0 || d_full[k] !== 1'b0 || d_empty[k] !== 1'b1 || d_err[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset[%0d]: addr=%0d full=%b empty=%b err=%b, want 0/0/1/0",
                 k, d_addr[k], d_full[k], d_empty[k], d_err[k]);
      end
    end
    @(negedge clk);
    i_up = 1'b0; i_ld = 1'b0; clr = 1'b1;
  endtask

  task automatic test_increment();
    for (int i = 0; i < AMAX + 2; i++) begin
      do_op(1, 0, 0, 0, 0, 0, 0);
      total++;
      if (d_addr[0] !== AW'((i + 1 > AMAX) ? AMAX : i + 1)) begin
        bad++;
        $display("FAIL inc_sat step %0d: addr=%0d want %0d", i, d_addr[0], (i + 1 > AMAX) ? AMAX : i + 1);
      end
      total++;
      if (d_addr[1] !== AW'((i + 1) % (AMAX + 1))) begin
        bad++;
        $display("FAIL inc_wrap step %0d: addr=%0d want %0d", i, d_addr[1], (i + 1) % (AMAX + 1));
      end
    end
  endtask

  task automatic test_wrap();
    do_op(0, 0, 1, 0, 0, 0, 7'd127);
    do_op(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (d_addr[0] !== 7'd127 || d_addr[1] !== 7'd0) begin
      bad++;
      $display("FAIL wrap: sat=%0d wrap=%0d want 127/0", d_addr[0], d_addr[1]);
    end
  endtask

  task automatic test_branch();
    logic [AW-1:0] offs [5] = '{7'h7D, 7'd5, 7'd0, 7'd5, 7'd0};
    int            exp  [5] = '{7, 12, 12, 3, 3};
    do_op(0, 0, 1, 0, 0, 0, 7'd10);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) do_op(0, 0, 1, 0, 0, 0, 7'd126);
      do_op(0, 1, 0, 0, 0, offs[i], 0);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (d_addr[k] !== AW'(exp[i])) begin
          bad++;
          $display("FAIL branch %0d[%0d]: addr=%0d want %0d", i, k, d_addr[k], exp[i]);
        end
      end
    end
  endtask

  task automatic test_call_ret();
    bit call_t [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    int tgt_t  [10] = '{40, 50, 60, 70, 80, 0, 0, 0, 0, 0};
    int exp_a  [10] = '{40, 50, 60, 70, 70, 61, 51, 41, 6, 6};
    bit exp_f  [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    bit exp_e  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    bit exp_r  [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    apply_reset();
    do_op(0, 0, 1, 0, 0, 0, 7'd5);
    for (int i = 0; i < 10; i++) begin
      do_op(0, 0, 0, call_t[i], !call_t[i], 0, AW'(tgt_t[i]));
      for (int k = 0; k < 2; k++) begin
        total++;
        if (d_addr[k] !== AW'(exp_a[i]) || d_full[k] !== exp_f[i] ||
            d_empty[k] !== exp_e[i] || d_err[k] !== exp_r[i]) begin
          bad++;
          $display("FAIL call_ret %0d[%0d]: addr=%0d f=%b e=%b err=%b want %0d/%b/%b/%b",
                   i, k, d_addr[k], d_full[k], d_empty[k], d_err[k],
                   exp_a[i], exp_f[i], exp_e[i], exp_r[i]);
        end
      end
    end
  endtask

  task automatic test_priority();
    apply_reset();
    do_op(0, 0, 1, 0, 0, 0, 7'd20);
    do_op(1, 1, 1, 0, 0, 7'd4, 7'd90);
    total++;
    if (d_addr[0] !== 7'd90) begin
      bad++;
      $display("FAIL prio_ld: addr=%0d want 90", d_addr[0]);
    end
    do_op(0, 0, 0, 1, 1, 0, 7'd30);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (d_addr[k] !== 7'd90 || d_err[k] !== 1'b1 || d_empty[k] !== 1'b1) begin
        bad++;
        $display("FAIL prio_ret[%0d]: addr=%0d err=%b empty=%b want 90/1/1",
                 k, d_addr[k], d_err[k], d_empty[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_op(0, 0, 1, 0, 0, 0, 7'd10);
    do_op(0, 0, 0, 1, 0, 0, 7'd20);
    do_op(0, 0, 0, 1, 0, 0, 7'd33);
    total++;
    if (d_addr[0] !== 7'd33 || d_empty[0] !== 1'b0 || d_err[0] !== 1'b1) begin
      bad++;
      $display("FAIL async_pre: addr=%0d empty=%b err=%b want 33/0/1", d_addr[0], d_empty[0], d_err[0]);
    end
    #2 clr = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (d_addr[k] !== 7'd0 || d_empty[k] !== 1'b1 || d_full[k] !== 1'b0 || d_err[k] !== 1'b0) begin
        bad++;
        $display("FAIL async_clr[%0d]: addr=%0d empty=%b full=%b err=%b want 0/1/0/0",
                 k, d_addr[k], d_empty[k], d_full[k], d_err[k]);
      end
    end
    #2 clr = 1'b1;
    do_op(1, 0, 0, 0, 0, 0, 0);
    total++;
    if (d_addr[0] !== 7'd1 || d_empty[0] !== 1'b1) begin
      bad++;
      $display("FAIL async_post: addr=%0d empty=%b want 1/1", d_addr[0], d_empty[0]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      do_op(($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15),
            AW'($urandom), AW'($urandom_range(AMAX - 8, AMAX)));
      for (int k = 0; k < 2; k++) begin
        total++;
        if (d_addr[k] !== AW'(m_addr[k]) || d_full[k] !== (m_sp[k] == DEPTH) ||
            d_empty[k] !== (m_sp[k] == 0) || d_err[k] !== m_err[k]) begin
          bad++;
          $display("FAIL random %0d[%0d]: addr=%0d f=%b e=%b err=%b want %0d/%b/%b/%b",
                   i, k, d_addr[k], d_full[k], d_empty[k], d_err[k],
                   m_addr[k], (m_sp[k] == DEPTH), (m_sp[k] == 0), m_err[k]);
        end
      end
      if ($urandom_range(0, 99) < 3) apply_reset();
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_wrap();
    test_branch();
    test_call_ret();
    test_priority();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
